// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: sequencer states and PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStepWait = 2'd2,
    StHalted   = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
  parameter int unsigned NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [NBITS-1:0] o_count
);

  logic [NBITS-1:0] r_count;

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {NBITS{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and fetch sequencer (run / single-step / halt).
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned      NBITS    = 32,
  parameter logic [NBITS-1:0] RESET_PC = NBITS'(DEFAULT_RESET_PC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NBITS-1:0] i_next_pc,
  input  logic             i_stall,
  input  logic             i_start,
  input  logic             i_mode_step,
  input  logic             i_step,
  input  logic             i_halt_instr,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_pc_plus4,
  output logic             o_fetch_en,
  output logic             o_halted,
  output logic             o_misaligned,
  output logic [NBITS-1:0] o_cycle_count
);

  fetch_state_e     r_state;
  logic [NBITS-1:0] r_pc;
  logic             r_halted;
  logic             r_misaligned;

  logic             w_adv;
  logic             w_start_ok;
  logic             w_halt_hit;
  logic [NBITS-1:0] w_cycle_count;

  // Advance decision; deliberately independent of i_next_pc to avoid a mux loop.
  always_comb begin
    w_adv = 1'b0;
    unique case (r_state)
      StRun:      w_adv = !i_stall && !i_halt_instr;
      StStepWait: w_adv = i_step && !i_stall && !i_halt_instr;
      StIdle:     w_adv = 1'b0;
      StHalted:   w_adv = 1'b0;
    endcase
  end

  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StHalted));
  assign w_halt_hit = i_halt_instr && !i_stall;

  // Sequencer FSM with PC, halted and misaligned flags as registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_adv) begin
        r_pc <= {i_next_pc[NBITS-1:2], 2'b00};
        if (i_next_pc[1:0] != 2'b00) begin
          r_misaligned <= 1'b1;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state      <= i_mode_step ? StStepWait : StRun;
            r_misaligned <= 1'b0;
          end
        end
        StRun: begin
          if (w_halt_hit) begin
            r_state  <= StHalted;
            r_halted <= 1'b1;
          end
        end
        StStepWait: begin
          // A stalled step pulse is simply dropped; the debug unit re-pulses.
          if (i_step && w_halt_hit) begin
            r_state  <= StHalted;
            r_halted <= 1'b1;
          end
        end
        StHalted: begin
          if (i_start) begin
            r_state      <= i_mode_step ? StStepWait : StRun;
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .NBITS(NBITS)
  ) u_cycle_counter (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_start_ok),
    .i_en   (w_adv),
    .o_count(w_cycle_count)
  );

  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc + NBITS'(PC_INCR);
  assign o_fetch_en    = w_adv;
  assign o_halted      = r_halted;
  assign o_misaligned  = r_misaligned;
  assign o_cycle_count = w_cycle_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        start;
  logic        mode_step;
  logic        step;
  logic        halt_instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_en;
  logic        halted;
  logic        misaligned;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_ctrl #(
    .NBITS   (32),
    .RESET_PC(32'h0)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_next_pc    (next_pc),
    .i_stall      (stall),
    .i_start      (start),
    .i_mode_step  (mode_step),
    .i_step       (step),
    .i_halt_instr (halt_instr),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .o_fetch_en   (fetch_en),
    .o_halted     (halted),
    .o_misaligned (misaligned),
    .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        mode_step;
    logic        step;
    logic        stall;
    logic        halt;
    logic [31:0] next_pc;
    logic        exp_fen;    // during the cycle
    logic [31:0] exp_pc;     // after the edge
    logic        exp_halted;
    logic        exp_mis;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic md, logic sp, logic sl, logic ht,
                              logic [31:0] np, logic fen, logic [31:0] epc,
                              logic eh, logic em, logic [31:0] ec);
    vec_t v;
    v.start = st; v.mode_step = md; v.step = sp; v.stall = sl; v.halt = ht;
    v.next_pc = np; v.exp_fen = fen; v.exp_pc = epc;
    v.exp_halted = eh; v.exp_mis = em; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic md, input logic sp, input logic sl,
                       input logic ht, input logic [31:0] np);
    start = st; mode_step = md; step = sp; stall = sl; halt_instr = ht; next_pc = np;
  endtask

  logic [31:0] exp_pc_prev;

  initial begin
    //            st md sp sl ht next           fen pc             h  m  cnt
    // Continuous run from reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h4,        0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h4,        1, 32'h4,        0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8,        1, 32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'hC,        1, 32'hC,        0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h10,       1, 32'h10,       0, 0, 4));
    // Two-cycle stall at 0x10
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h14,       0, 32'h10,       0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h14,       0, 32'h10,       0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h14,       1, 32'h14,       0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h20,       1, 32'h20,       0, 0, 6));
    // HALT with stall, then alone
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h24,       0, 32'h20,       0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h24,       0, 32'h20,       1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h24,       0, 32'h20,       1, 0, 6));
    // Restart, misaligned advance
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h24,       0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h1003,     1, 32'h1000,     0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h1004,     1, 32'h1004,     0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h1008,     0, 32'h1004,     1, 1, 2));
    // Restart into step mode clears misaligned
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h40,       0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h40,       0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h40,       0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h40,       1, 32'h40,       0, 0, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h80,     0, 32'h40,       0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h80,       0, 32'h40,       0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h80,       1, 32'h80,       0, 0, 2));
    // Start ignored in step mode: no advance without a step
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'hC0,       0, 32'h80,       0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'hC0,       0, 32'h80,       0, 0, 2));
    // Step onto HALT, then step ignored while halted
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'hC0,       0, 32'h80,       1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'hC0,       0, 32'h80,       1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h50,       0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h50,       1, 32'h50,       0, 0, 1));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset cycle_count", cycle_count, 32'h0);
    chk("reset halted", {31'b0, halted}, 32'h0);
    chk("reset misaligned", {31'b0, misaligned}, 32'h0);
    chk("reset fetch_en", {31'b0, fetch_en}, 32'h0);
    rst_n = 1'b1;

    exp_pc_prev = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].mode_step, vecs[i].step, vecs[i].stall,
            vecs[i].halt, vecs[i].next_pc);
      #1;
      chk($sformatf("v%0d fetch_en", i), {31'b0, fetch_en}, {31'b0, vecs[i].exp_fen});
      chk($sformatf("v%0d pc_plus4", i), pc_plus4, exp_pc_prev + 32'd4);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
      chk($sformatf("v%0d misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("v%0d cycle_count", i), cycle_count, vecs[i].exp_cnt);
      exp_pc_prev = vecs[i].exp_pc;
    end

    // Asynchronous reset between edges while running at 0x50
    drive(0, 0, 0, 0, 0, 32'h58);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst pc", pc, 32'h0);
    chk("async rst cycle_count", cycle_count, 32'h0);
    chk("async rst fetch_en", {31'b0, fetch_en}, 32'h0);
    chk("async rst halted", {31'b0, halted}, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 1, 0, 0, 32'h60);
    #1;
    chk("idle step fetch_en", {31'b0, fetch_en}, 32'h0);
    @(posedge clk);
    #1;
    chk("idle step pc", pc, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h60);
    @(posedge clk);
    #1;
    chk("restart pc", pc, 32'h0);
    // Wrap of pc_plus4 at the top of the address space
    drive(0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    #1;
    chk("wrap fetch_en", {31'b0, fetch_en}, 32'h1);
    @(posedge clk);
    #1;
    chk("wrap pc", pc, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4, 32'h0);
    chk("wrap misaligned", {31'b0, misaligned}, 32'h1);
    chk("wrap cycle_count", cycle_count, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and fetch sequencer for the IF stage. Consumes the next-PC value produced by the next-PC selection mux, holds the architectural PC, and decides each cycle whether the PC advances. Advancement is gated by hazard stall, debug single-step and HALT detection. Exports PC, PC+4 (fed back to the mux) and a fetch-enable, halted status and cycle count toward the debug unit.

## Interface
- NBITS, 32, PC/data width
- RESET_PC, 0, PC value after reset and after restart

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_next_pc  in  NBITS  next PC from the selection mux
- i_stall  in  1  load-use/hazard stall; PC must hold
- i_start  in  1  one-cycle pulse from debug unit: begin/restart execution
- i_mode_step  in  1  sampled with i_start: 1 = single-step mode, 0 = continuous
- i_step  in  1  one-cycle pulse: execute one instruction (step mode only)
- i_halt_instr  in  1  instruction at o_pc decodes as HALT
- o_pc  out  NBITS  current PC, registered
- o_pc_plus4  out  NBITS  o_pc + 4, combinational, modulo 2^NBITS
- o_fetch_en  out  1  combinational; PC advances at the next edge, IF/ID captures
- o_halted  out  1  registered; state is HALTED
- o_misaligned  out  1  sticky; an advance loaded i_next_pc with nonzero bits [1:0]
- o_cycle_count  out  NBITS  advancing cycles since start, saturating

## Operation
- States: IDLE, RUN, STEP_WAIT, HALTED.
- Reset (async, immediate): state IDLE, o_pc = RESET_PC, o_cycle_count = 0, o_misaligned = 0, o_halted = 0.
- Advance condition adv, used as o_fetch_en:
  - RUN: adv = !i_stall && !i_halt_instr.
  - STEP_WAIT: adv = i_step && !i_stall && !i_halt_instr.
  - IDLE and HALTED: adv = 0.
- On adv: o_pc <= {i_next_pc[NBITS-1:2], 2'b00}; o_cycle_count increments, saturating at all-ones.
- On adv with i_next_pc[1:0] != 0: o_misaligned <= 1. It clears only on reset or accepted i_start.
- IDLE: on i_start, go to STEP_WAIT if i_mode_step = 1, else RUN. No PC change.
- RUN: if i_halt_instr && !i_stall, go to HALTED; o_pc holds at the HALT address.
- STEP_WAIT: on i_step with i_halt_instr && !i_stall, go to HALTED without advancing. A stalled i_step is consumed with no advance; the debug unit must re-pulse.
- HALTED: hold o_pc. On i_start: o_pc <= RESET_PC, o_cycle_count <= 0, o_misaligned <= 0, then go to RUN or STEP_WAIT per i_mode_step.
- Ignored inputs: i_start in RUN/STEP_WAIT, i_step in IDLE/RUN/HALTED.
- Priority: reset > i_stall > i_halt_instr > advance.

## Timing
- o_pc latency: i_next_pc sampled at the edge where o_fetch_en = 1; visible on o_pc one cycle later.
- o_pc_plus4 and o_fetch_en are same-cycle combinational. o_fetch_en must not depend on i_next_pc, so there is no loop through the mux.
- Start latency: i_start at edge N; first advance possible in the cycle after N (RUN).
- o_halted rises the cycle after the HALT-detect edge. It falls the cycle after the restart edge.
- Reset asserted mid-run: outputs go to reset values without waiting for a clock edge. Release is synchronous to the next edge; the upstream reset synchronizer handles release.

## Structure
- Shared package mips_pkg:
  - fetch state enum (IDLE, RUN, STEP_WAIT, HALTED), 2 bits
  - PC_INCR = 4
  - default RESET_PC constant
- Sub-module sat_counter (NBITS, enable, synchronous clear, async active-low reset), instantiated for o_cycle_count.
- FSM and PC register stay in pc_fetch_ctrl.

## Test plan
- Reset, then i_start with mode_step = 0, i_next_pc = o_pc_plus4, no stalls: o_pc goes 0x0, 0x4, 0x8, 0xC over successive cycles; o_cycle_count = 3 after the third advance.
- RUN, i_stall high for 2 cycles at o_pc = 0x10: o_pc holds 0x10, o_fetch_en = 0, count frozen, then resumes to 0x14.
- Step mode, two i_step pulses 5 cycles apart, i_next_pc = 0x40 then 0x80: o_pc changes only after each pulse (0x0 → 0x40 → 0x80); i_step during i_stall produces no change.
- i_halt_instr at o_pc = 0x20 together with i_stall for 1 cycle, then alone:
  - no halt while stalled
  - halt next cycle; o_halted = 1, o_pc = 0x20
  - i_start then returns o_pc to RESET_PC and count to 0.
- Advance with i_next_pc = 0x1003: o_pc = 0x1000, o_misaligned = 1 and stays 1; i_start from HALTED clears it.
- i_rst_n asserted asynchronously mid-RUN (between edges) at o_pc = 0x50: o_pc = 0 immediately, state IDLE, i_step ignored until i_start.
